// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and constants for sequential arithmetic blocks
package arith_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_n.sv
// rtl/rca_n.sv - parameterised ripple-carry adder built from full-adder cells
module rca_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/seq_mult4.sv
// rtl/seq_mult4.sv - shift-and-add unsigned multiplier, one partial product per clock
module seq_mult4
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             c_add;
  logic [WIDTH-1:0] acc_add;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] q_nxt;

  rca_n #(.WIDTH(WIDTH)) u_rca (
    .a    (acc),
    .b    (m),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Carry is kept and shifted into the acc MSB so the product stays exact.
  always_comb begin
    c_add   = q[0] ? cout : 1'b0;
    acc_add = q[0] ? sum : acc;
    acc_nxt = {c_add, acc_add[WIDTH-1:1]};
    q_nxt   = {acc_add[0], q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            p     <= {acc_nxt, q_nxt};
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult4.sv
// tb/tb_seq_mult4.sv - directed and random self-checking bench for seq_mult4
module tb_seq_mult4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int tests = 0;
  int fails = 0;

  seq_mult4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start, returns product seen with done, its cycle index after the
  // accepting edge (0 if never seen), and done/busy one cycle later.
  task automatic do_mult(input logic [3:0] ia, input logic [3:0] ib,
                         output logic [7:0] op, output int lat,
                         output logic done_after, output logic busy_after);
    a = ia;
    b = ib;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    op = 'x;
    for (int idx = 1; idx <= 12; idx++) begin
      if (done === 1'b1) begin
        lat = idx;
        op = p;
        break;
      end
      tick();
    end
    tick();
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++;
    if (p !== 8'h00) begin fails++; $display("FAIL reset_p: got %h want 00", p); end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL reset_idle_done cycle %0d: got %b want 0", i, done); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] op;
    int lat;
    logic da, ba;
    do_mult(4'd3, 4'd5, op, lat, da, ba);
    tests++;
    if (lat !== 5) begin fails++; $display("FAIL basic_latency: got %0d want 5", lat); end
    tests++;
    if (op !== 8'h0F) begin fails++; $display("FAIL basic_p: got %h want 0f", op); end
    tests++;
    if (da !== 1'b0 || ba !== 1'b0) begin
      fails++; $display("FAIL basic_pulse: done=%b busy=%b want 0 0", da, ba);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (p !== 8'h0F || done !== 1'b0) begin
        fails++; $display("FAIL basic_hold cycle %0d: p=%h done=%b want 0f 0", i, p, done);
      end
    end
  endtask

  task automatic test_corners();
    logic [3:0] ca [4] = '{4'd0, 4'd15, 4'd15, 4'd1};
    logic [3:0] cb [4] = '{4'd9, 4'd15, 4'd1, 4'd15};
    logic [7:0] ce [4] = '{8'h00, 8'hE1, 8'h0F, 8'h0F};
    logic [7:0] op;
    int lat;
    logic da, ba;
    for (int i = 0; i < 4; i++) begin
      do_mult(ca[i], cb[i], op, lat, da, ba);
      tests++;
      if (op !== ce[i] || lat !== 5) begin
        fails++;
        $display("FAIL corner %0dx%0d: p=%h lat=%0d want %h lat=5", ca[i], cb[i], op, lat, ce[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    logic [7:0] got = '0;
    a = 4'd7;
    b = 4'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int idx = 1; idx <= 16; idx++) begin
      if (done === 1'b1) begin
        ndone++;
        got = p;
      end
      start = (idx == 2 || idx == 5) ? 1'b1 : 1'b0;
      a = 4'd2;
      b = 4'd2;
      tick();
    end
    start = 1'b0;
    tests++;
    if (ndone !== 1) begin fails++; $display("FAIL busy_start_count: got %0d done pulses want 1", ndone); end
    tests++;
    if (got !== 8'h2A) begin fails++; $display("FAIL busy_start_p: got %h want 2a", got); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_start_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] op;
    int lat;
    logic da, ba;
    int ndone = 0;
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
      fails++; $display("FAIL rst_mid_state: busy=%b done=%b p=%h want 0 0 00", busy, done, p);
    end
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    tests++;
    if (ndone !== 0) begin fails++; $display("FAIL rst_mid_nodone: got %0d pulses want 0", ndone); end
    do_mult(4'd9, 4'd9, op, lat, da, ba);
    tests++;
    if (op !== 8'h51 || lat !== 5) begin
      fails++; $display("FAIL rst_mid_fresh: p=%h lat=%0d want 51 lat=5", op, lat);
    end
  endtask

  task automatic test_back_to_back();
    int prev = -1;
    int ndone = 0;
    a = 4'd4;
    b = 4'd4;
    start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        tests++;
        if (p !== 8'h10) begin fails++; $display("FAIL b2b_p cycle %0d: got %h want 10", cyc, p); end
        if (prev >= 0) begin
          tests++;
          if (cyc - prev !== 6) begin
            fails++; $display("FAIL b2b_interval: got %0d want 6", cyc - prev);
          end
        end
        prev = cyc;
      end
    end
    start = 1'b0;
    tests++;
    if (ndone < 6) begin fails++; $display("FAIL b2b_count: got %0d pulses want >= 6", ndone); end
    for (int i = 0; i < 10 && busy === 1'b1; i++) tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_drain: busy=%b want 0", busy); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] ra, rb;
    logic [7:0] op, exp_p;
    int lat;
    logic da, ba;
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      exp_p = 8'(ra) * 8'(rb);
      do_mult(ra, rb, op, lat, da, ba);
      tests++;
      if (op !== exp_p || lat !== 5 || da !== 1'b0) begin
        fails++;
        $display("FAIL random %0dx%0d: p=%h lat=%0d done_after=%b want %h lat=5 0", ra, rb, op, lat, da, exp_p);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_corners();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_mult4.md
# seq_mult4

Sequential shift-and-add unsigned multiplier that consumes the sum and carry of the team's ripple-carry adder stage, one partial product per clock. It accepts two WIDTH-bit operands on a start pulse and produces a 2·WIDTH-bit product after WIDTH iterations, signalling completion with a one-cycle done pulse. It is the first arithmetic consumer of the parallel adder and serves as the multiply path of the datapath.

## Interface
- WIDTH, default 4: operand width in bits; product width is 2·WIDTH.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high; one clock; reset is synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, unsigned; captured when start is accepted.
- b  input  WIDTH  multiplier, unsigned; captured when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; p valid in that cycle.
- p  output  2·WIDTH  product, registered; holds until the next accepted start.

## Operation
- States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE: start=1 → capture m←a, q←b, acc←0, cnt←0; go to RUN. start=0 → stay.
- RUN, per cycle: if q[0]=1, {c,acc} ← acc + m (WIDTH-bit adder, carry out c); else {c,acc} ← {0,acc}. Then {c,acc,q} shift right one bit: acc ← {c,acc[WIDTH-1:1]}, q ← {acc_new[0],q[WIDTH-1:1]}. cnt ← cnt+1.
- After WIDTH RUN cycles (cnt = WIDTH-1 on the last one): p ← {acc,q} (post-shift values); go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE unconditionally.
- start outside IDLE is ignored; it is not queued.
- Arithmetic: all unsigned; product exact, no overflow (max (2^WIDTH−1)² fits 2·WIDTH bits). Carry out of the adder is never dropped; it enters acc MSB on the shift.
- a and b may change freely after acceptance; only captured copies are used.
- cnt width: clog2(WIDTH)+1 bits.

## Timing
- Reset values: state=IDLE, busy=0, done=0, p=0, acc=0, q=0, m=0, cnt=0.
- rst has priority over every other input; rst high mid-RUN or in DONE → IDLE on the next edge, no done pulse, p cleared to 0.
- start high at edge k (IDLE) → busy=1 from cycle k+1; RUN edges k+1..k+WIDTH; done=1 and p valid in cycle k+WIDTH+1; busy=0 and IDLE from cycle k+WIDTH+2.
- Latency start-to-done: WIDTH+1 cycles (5 for WIDTH=4). Throughput: one multiply every WIDTH+2 cycles; earliest next accepted start is the edge ending the first IDLE cycle after DONE.
- p changes only on the DONE transition edge and on reset.
- busy and done are registered; no combinational path from inputs to outputs.

## Structure
- Shared package arith_pkg: state enum (IDLE, RUN, DONE) and default WIDTH constant, reused by later sequential arithmetic blocks.
- One sub-module: rca_n, a WIDTH-parameterised ripple-carry adder (a, b, cin=0 → sum, cout) built from full-adder cells; instantiated once for acc + m.
- Remaining logic (FSM, counter, shift registers, output register) lives in seq_mult4.

## Test plan
- Reset: hold rst 2 cycles → busy=0, done=0, p=0x00; no done pulse while start=0 for 10 cycles.
- Basic: a=3, b=5, start 1 cycle → done exactly 5 cycles after the accepting edge, p=0x0F; p holds 0x0F for 20 idle cycles.
- Corners: 0×9 → p=0x00; 15×15 → p=0xE1 (exercises carry into acc MSB); 15×1 → 0x0F; 1×15 → 0x0F.
- Start while busy: accept 7×6, pulse start with a=2, b=2 in RUN and in DONE → single done, p=0x2A; no second result.
- Reset mid-operation: accept 9×9, assert rst at 2nd RUN cycle → no done, p=0x00, IDLE next cycle; a fresh 9×9 then yields p=0x51.
- Back-to-back: hold start=1 continuously with a=4, b=4 → done pulses every 6 cycles, each with p=0x10; random 200-pair sweep vs a×b reference model.
